line_window_gen: RTL and testbench

Downstream consumer of the line-buffer SRAM controller. It takes the KER_SIZE rows read each cycle from the (KER_SIZE+1) rotating row banks and reorders them oldest-to-newest. It applies vertical pad masks, builds a KER_SIZE x KER_SIZE x NFMAPS sliding window with left/right zero padding and column stride, and presents one registered window per output column to the convolution datapath.

---
 rtl/line_window_gen.sv | 187 ++++++++++++++++++
 tb/tb_line_window_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_gen.sv
// line_window_gen: reorders line-buffer bank reads oldest-to-newest, applies vertical pad masks and
// emits registered KxK sliding windows with left/right zero padding and column stride.
// Define LINE_WIN_CNT_EN to add o_win_count, a 16-bit wrapping count of emitted windows.
module line_window_gen #(
    parameter int unsigned KER_SIZE    = 3,
    parameter int unsigned BITWIDTH    = 8,
    parameter int unsigned NFMAPS      = 3,
    parameter int unsigned INPUT_X_DIM = 28,
    parameter int unsigned PAD         = 1,
    parameter int unsigned STRIDE      = 1
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_in_valid,
    input  logic [(KER_SIZE+1)*NFMAPS*BITWIDTH-1:0]      i_rd_data,
    input  logic [KER_SIZE:0]                            i_wr_bank,
    input  logic [KER_SIZE-1:0]                          i_top_pad_mask,
    input  logic                                         i_bottom_pad_mask,
    output logic                                         o_in_ready,
    output logic                                         o_win_valid,
    output logic [KER_SIZE*KER_SIZE*NFMAPS*BITWIDTH-1:0] o_win_data,
    output logic [7:0]                                   o_win_col,
    output logic                                         o_row_done,
    output logic                                         o_overrun
`ifdef LINE_WIN_CNT_EN
    ,
    output logic [15:0]                                  o_win_count
`endif
);

    localparam int unsigned FW       = NFMAPS * BITWIDTH;
    localparam int unsigned NWIN     = (INPUT_X_DIM + 2 * PAD - KER_SIZE) / STRIDE + 1;
    localparam logic [7:0]  PAD_PC   = 8'(PAD);
    localparam logic [7:0]  KM1      = 8'(KER_SIZE - 1);
    localparam logic [7:0]  STR      = 8'(STRIDE);
    localparam logic [7:0]  LAST_WIN = 8'(NWIN - 1);
    localparam logic [7:0]  XDIM     = 8'(INPUT_X_DIM);

    typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

    state_e        r_state;
    logic [FW-1:0] r_sr [KER_SIZE][KER_SIZE];  // [column][row], column KER_SIZE-1 is newest
    logic [7:0]    r_pc;
    logic [7:0]    r_in_cnt;
    logic [7:0]    r_flush_cnt;
    logic [7:0]    r_win_idx;
    logic [7:0]    r_win_col;
    logic          r_in_ready;
    logic          r_win_valid;
    logic          r_row_done;
    logic          r_overrun;

    logic [FW-1:0] w_col [KER_SIZE];
    int unsigned   w_wr_idx;
    logic          w_accept;
    logic          w_shift;
    logic          w_emit;
    logic [7:0]    w_pc_nx;

    // The bank after the one being written holds the oldest row.
    always_comb begin
        w_wr_idx = 0;
        for (int unsigned b = 0; b <= KER_SIZE; b++) begin
            if (i_wr_bank[b]) w_wr_idx = b;
        end
        for (int unsigned r = 0; r < KER_SIZE; r++) begin
            w_col[r] = '0;
            for (int unsigned b = 0; b <= KER_SIZE; b++) begin
                if (b == (w_wr_idx + 1 + r) % (KER_SIZE + 1)) w_col[r] = i_rd_data[b*FW +: FW];
            end
            if (i_top_pad_mask[r] || (r == KER_SIZE - 1 && i_bottom_pad_mask)) w_col[r] = '0;
        end
    end

    always_comb begin
        w_accept = i_in_valid && r_in_ready;
        w_shift  = w_accept || (r_state == StFlush);
        w_pc_nx  = (r_state == StIdle) ? PAD_PC : r_pc + 8'd1;
        w_emit   = w_shift && (w_pc_nx >= KM1) && (((w_pc_nx - KM1) % STR) == 8'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            for (int unsigned c = 0; c < KER_SIZE; c++) begin
                for (int unsigned r = 0; r < KER_SIZE; r++) r_sr[c][r] <= '0;
            end
            r_pc        <= '0;
            r_in_cnt    <= '0;
            r_flush_cnt <= '0;
            r_win_idx   <= '0;
            r_win_col   <= '0;
            r_in_ready  <= 1'b1;
            r_win_valid <= 1'b0;
            r_row_done  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_win_valid <= w_emit;
            r_row_done  <= w_emit && (r_win_idx == LAST_WIN);
            if (w_emit) begin
                r_win_col <= r_win_idx;
                r_win_idx <= (r_win_idx == LAST_WIN) ? 8'd0 : r_win_idx + 8'd1;
            end
            if (i_in_valid && !r_in_ready) r_overrun <= 1'b1;

            // First column of a row clears the older columns, giving the implicit left pad.
            if (w_shift) begin
                r_pc <= w_pc_nx;
                for (int unsigned c = 0; c + 1 < KER_SIZE; c++) begin
                    for (int unsigned r = 0; r < KER_SIZE; r++) begin
                        r_sr[c][r] <= (r_state == StIdle) ? '0 : r_sr[c+1][r];
                    end
                end
                for (int unsigned r = 0; r < KER_SIZE; r++) begin
                    r_sr[KER_SIZE-1][r] <= (r_state == StFlush) ? '0 : w_col[r];
                end
            end

            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_in_cnt    <= 8'd1;
                        r_flush_cnt <= 8'd0;
                        if (XDIM != 8'd1) begin
                            r_state <= StStream;
                        end else if (PAD > 0) begin
                            r_state    <= StFlush;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                StStream: begin
                    if (w_accept) begin
                        r_in_cnt <= r_in_cnt + 8'd1;
                        if (r_in_cnt + 8'd1 == XDIM) begin
                            if (PAD > 0) begin
                                r_state     <= StFlush;
                                r_in_ready  <= 1'b0;
                                r_flush_cnt <= 8'd0;
                            end else begin
                                r_state <= StIdle;
                            end
                        end
                    end
                end
                StFlush: begin
                    r_flush_cnt <= r_flush_cnt + 8'd1;
                    if (r_flush_cnt + 8'd1 == PAD_PC) begin
                        r_state    <= StIdle;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_win_data = '0;
        for (int unsigned r = 0; r < KER_SIZE; r++) begin
            for (int unsigned c = 0; c < KER_SIZE; c++) begin
                o_win_data[(r*KER_SIZE + c)*FW +: FW] = r_sr[c][r];
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_win_valid = r_win_valid;
    assign o_win_col   = r_win_col;
    assign o_row_done  = r_row_done;
    assign o_overrun   = r_overrun;

`ifdef LINE_WIN_CNT_EN
    logic [15:0] r_win_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_win_count <= '0;
        end else if (r_win_valid) begin
            r_win_count <= r_win_count + 16'd1;
        end
    end

    assign o_win_count = r_win_count;
`endif

endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: a directed bank-rotation table, ramp rows and randomised rows scored
// against a padded-row window model; a second instance runs with STRIDE=2 on the same inputs.
module tb_line_window_gen;
    localparam int K   = 3;
    localparam int BW  = 8;
    localparam int NF  = 3;
    localparam int X   = 28;
    localparam int PAD = 1;
    localparam int FW  = NF * BW;
    localparam int CW  = K * FW;
    localparam int WW  = K * K * FW;
    localparam int RW  = (K + 1) * FW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [RW-1:0] rd_data;
    logic [K:0]    wr_bank;
    logic [K-1:0]  tmask;
    logic          bmask;
    logic          in_ready1, win_valid1, row_done1, overrun1;
    logic          in_ready2, win_valid2, row_done2, overrun2;
    logic [WW-1:0] win_data1, win_data2;
    logic [7:0]    win_col1, win_col2;
`ifdef LINE_WIN_CNT_EN
    logic [15:0]   win_count1, win_count2;
`endif

    line_window_gen #(.STRIDE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_rd_data(rd_data),
        .i_wr_bank(wr_bank), .i_top_pad_mask(tmask), .i_bottom_pad_mask(bmask),
        .o_in_ready(in_ready1), .o_win_valid(win_valid1), .o_win_data(win_data1),
        .o_win_col(win_col1), .o_row_done(row_done1), .o_overrun(overrun1)
`ifdef LINE_WIN_CNT_EN
        , .o_win_count(win_count1)
`endif
    );

    line_window_gen #(.STRIDE(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_rd_data(rd_data),
        .i_wr_bank(wr_bank), .i_top_pad_mask(tmask), .i_bottom_pad_mask(bmask),
        .o_in_ready(in_ready2), .o_win_valid(win_valid2), .o_win_data(win_data2),
        .o_win_col(win_col2), .o_row_done(row_done2), .o_overrun(overrun2)
`ifdef LINE_WIN_CNT_EN
        , .o_win_count(win_count2)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WW-1:0] d;
        logic [7:0]    col;
        logic          done;
        int            cyc;
    } win_t;

    win_t q1[$];
    win_t q2[$];

    always @(negedge clk) begin
        win_t w;
        if (win_valid1) begin
            w.d = win_data1; w.col = win_col1; w.done = row_done1; w.cyc = cyc;
            q1.push_back(w);
        end
        if (win_valid2) begin
            w.d = win_data2; w.col = win_col2; w.done = row_done2; w.cyc = cyc;
            q2.push_back(w);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Per-row model state: ordered, masked input columns and the cycle each was driven.
    logic [CW-1:0] expcol [X];
    int            acc    [X];

    function automatic logic [CW-1:0] order_col(input logic [RW-1:0] rd, input logic [K:0] wb,
                                                input logic [K-1:0] tm, input logic bm);
        logic [CW-1:0] res;
        int w = 0;
        for (int b = 0; b <= K; b++) if (wb[b]) w = b;
        for (int r = 0; r < K; r++) begin
            res[r*FW +: FW] = rd[((w + 1 + r) % (K + 1))*FW +: FW];
            if (tm[r] || (r == K - 1 && bm)) res[r*FW +: FW] = '0;
        end
        return res;
    endfunction

    function automatic logic [RW-1:0] rand_rd();
        logic [RW-1:0] t;
        for (int j = 0; j < RW / 8; j++) t[j*8 +: 8] = 8'($urandom_range(0, 255));
        return t;
    endfunction

    function automatic logic [CW-1:0] rep(input logic [7:0] v);
        logic [CW-1:0] t;
        for (int j = 0; j < CW / 8; j++) t[j*8 +: 8] = v;
        return t;
    endfunction

    function automatic logic [CW-1:0] colslice(input logic [WW-1:0] d, input int c);
        logic [CW-1:0] t;
        for (int r = 0; r < K; r++) t[r*FW +: FW] = d[(r*K + c)*FW +: FW];
        return t;
    endfunction

    function automatic logic [CW-1:0] rowslice(input logic [WW-1:0] d, input int r);
        return d[r*CW +: CW];
    endfunction

    // mode 0: ramp (all bytes = column+1), 1: bank b bytes = b+1, 2: random data/banks/masks.
    // gaps 0: none, 1: one idle cycle between columns, 2: random idle cycles.
    task automatic drive_row(input int mode, input logic [K:0] wb, input logic [K-1:0] tm,
                             input logic bm, input int gaps, input bit poke);
        logic [RW-1:0] rd;
        logic [K:0]    b;
        logic [K-1:0]  t;
        logic          m;
        int            ng;
        q1.delete();
        q2.delete();
        for (int i = 0; i < X; i++) begin
            ng = 0;
            if (gaps == 1 && i > 0) ng = 1;
            if (gaps == 2) ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++) begin
                in_valid = 1'b0;
                rd_data  = rand_rd();
                @(posedge clk); #1;
            end
            b = wb; t = tm; m = bm;
            if (mode == 0) begin
                for (int j = 0; j < RW / 8; j++) rd[j*8 +: 8] = 8'(i + 1);
            end else if (mode == 1) begin
                for (int bk = 0; bk <= K; bk++)
                    for (int j = 0; j < FW / 8; j++) rd[bk*FW + j*8 +: 8] = 8'(bk + 1);
            end else begin
                rd = rand_rd();
                b  = {{K{1'b0}}, 1'b1} << $urandom_range(0, K);
                t  = ($urandom_range(0, 3) == 0) ? K'($urandom_range(0, (1 << K) - 1)) : '0;
                m  = ($urandom_range(0, 5) == 0);
            end
            expcol[i] = order_col(rd, b, t, m);
            in_valid  = 1'b1;
            rd_data   = rd;
            wr_bank   = b;
            tmask     = t;
            bmask     = m;
            acc[i]    = cyc;
            @(posedge clk); #1;
        end
        chk("in_ready_low_in_flush", 256'(in_ready1), 256'(1'b0));
        in_valid = poke;
        for (int j = 0; j < RW / 8; j++) rd[j*8 +: 8] = 8'hAA;
        rd_data = rd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_back_high", 256'(in_ready1), 256'(1'b1));
        if (poke) chk("overrun_set", 256'(overrun1), 256'(1'b1));
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Windows from the padded row: window j covers padded columns j*s .. j*s+K-1.
    task automatic check_windows(input int s);
        logic [CW-1:0] padc [X + 2*PAD];
        logic [WW-1:0] ed;
        win_t          w;
        int            nw, q, ecyc, got;
        for (int i = 0; i < X + 2*PAD; i++) begin
            if (i < PAD || i >= PAD + X) padc[i] = '0;
            else                         padc[i] = expcol[i - PAD];
        end
        nw  = (X + 2*PAD - K) / s + 1;
        got = (s == 1) ? q1.size() : q2.size();
        chk($sformatf("s%0d_num_windows", s), 256'(got), 256'(nw));
        for (int j = 0; j < nw && j < got; j++) begin
            if (s == 1) w = q1[j];
            else        w = q2[j];
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) ed[(r*K + c)*FW +: FW] = padc[j*s + c][r*FW +: FW];
            q    = j*s + K - 1 - PAD;
            ecyc = (q < X) ? acc[q] + 1 : acc[X-1] + 1 + (q - X + 1);
            chk($sformatf("s%0d_win_data_%0d", s, j), 256'(w.d), 256'(ed));
            chk($sformatf("s%0d_win_col_%0d", s, j), 256'(w.col), 256'(j));
            chk($sformatf("s%0d_row_done_%0d", s, j), 256'(w.done), 256'(j == nw - 1));
            chk($sformatf("s%0d_latency_%0d", s, j), 256'(w.cyc), 256'(ecyc));
        end
    endtask

    typedef struct {
        logic [K:0]   wb;
        logic [K-1:0] tm;
        logic         bm;
        logic [7:0]   e0, e1, e2;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{4'b0010, 3'b000, 1'b0, 8'd3, 8'd4, 8'd1};
        tbl[1] = '{4'b0010, 3'b001, 1'b0, 8'd0, 8'd4, 8'd1};
        tbl[2] = '{4'b0010, 3'b000, 1'b1, 8'd3, 8'd4, 8'd0};
        tbl[3] = '{4'b0001, 3'b000, 1'b0, 8'd2, 8'd3, 8'd4};
        tbl[4] = '{4'b1000, 3'b000, 1'b0, 8'd1, 8'd2, 8'd3};
        tbl[5] = '{4'b0100, 3'b110, 1'b0, 8'd4, 8'd0, 8'd0};

        rst = 1'b1; in_valid = 1'b0; rd_data = '0; wr_bank = 4'b0001; tmask = '0; bmask = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 256'(in_ready1), 256'(1'b1));
        chk("rst_win_valid", 256'(win_valid1), 256'(1'b0));
        chk("rst_row_done", 256'(row_done1), 256'(1'b0));
        chk("rst_overrun", 256'(overrun1), 256'(1'b0));
        chk("rst_win_data", 256'(win_data1), 256'(0));
        chk("rst_win_col", 256'(win_col1), 256'(0));

        // Ramp row, masks clear.
        drive_row(0, 4'b0001, 3'b000, 1'b0, 0, 1'b0);
        check_windows(1);
        check_windows(2);
        chk("ramp_s1_count", 256'(q1.size()), 256'(28));
        chk("ramp_s2_count", 256'(q2.size()), 256'(14));
        if (q1.size() == 28) begin
            chk("ramp_w0_c0_left_pad", 256'(colslice(q1[0].d, 0)), 256'(0));
            chk("ramp_w27_c2_right_pad", 256'(colslice(q1[27].d, 2)), 256'(0));
            chk("ramp_w27_c1", 256'(colslice(q1[27].d, 1)), 256'(rep(8'd28)));
            chk("ramp_w27_col", 256'(q1[27].col), 256'(27));
            chk("ramp_w27_row_done", 256'(q1[27].done), 256'(1'b1));
        end
        if (q2.size() == 14) begin
            chk("ramp_s2_w0_centre", 256'(colslice(q2[0].d, 1)), 256'(rep(8'd1)));
            chk("ramp_s2_w13_centre", 256'(colslice(q2[13].d, 1)), 256'(rep(8'd27)));
            chk("ramp_s2_w13_col", 256'(q2[13].col), 256'(13));
        end

        // Bank rotation and pad masks.
        for (int i = 0; i < 6; i++) begin
            drive_row(1, tbl[i].wb, tbl[i].tm, tbl[i].bm, 0, 1'b0);
            check_windows(1);
            if (q1.size() > 5) begin
                chk($sformatf("tbl%0d_row0", i), 256'(rowslice(q1[5].d, 0)), 256'(rep(tbl[i].e0)));
                chk($sformatf("tbl%0d_row1", i), 256'(rowslice(q1[5].d, 1)), 256'(rep(tbl[i].e1)));
                chk($sformatf("tbl%0d_row2", i), 256'(rowslice(q1[5].d, 2)), 256'(rep(tbl[i].e2)));
            end
        end

        // Alternating bubbles: same windows, each one cycle after its column.
        drive_row(0, 4'b0001, 3'b000, 1'b0, 1, 1'b0);
        check_windows(1);
        check_windows(2);

        // Column offered during the right-pad flush is dropped and flagged.
        drive_row(2, 4'b0001, 3'b000, 1'b0, 0, 1'b1);
        check_windows(1);
        check_windows(2);

        for (int n = 0; n < 3; n++) begin
            drive_row(2, 4'b0001, 3'b000, 1'b0, 2, 1'b0);
            check_windows(1);
            check_windows(2);
        end
        chk("overrun_sticky", 256'(overrun1), 256'(1'b1));

        // Reset in the middle of a row.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; rd_data = rand_rd(); wr_bank = 4'b0001; tmask = '0; bmask = 1'b0;
            @(posedge clk); #1;
        end
        chk("pre_rst_win_valid", 256'(win_valid1), 256'(1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_win_valid", 256'(win_valid1), 256'(1'b0));
        chk("midrst_win_col", 256'(win_col1), 256'(0));
        chk("midrst_overrun", 256'(overrun1), 256'(1'b0));
        chk("midrst_in_ready", 256'(in_ready1), 256'(1'b1));
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        drive_row(2, 4'b0001, 3'b000, 1'b0, 0, 1'b0);
        check_windows(1);
        check_windows(2);

`ifdef LINE_WIN_CNT_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 3; n++) drive_row(0, 4'b0001, 3'b000, 1'b0, 0, 1'b0);
        chk("win_count_s1", 256'(win_count1), 256'(84));
        chk("win_count_s2", 256'(win_count2), 256'(42));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("win_count_rst", 256'(win_count1), 256'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
